// File: rtl/popcount_chunk_sequencer.sv
// Multi-cycle population count: a WIDTH-bit word is counted CHUNK bits per cycle.
// Optional macro POPCNT_EARLY_EXIT_EN ends the count once the remaining bits are all zero.
module popcount_chunk_sequencer #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   data_val_i,
  output logic                   data_ready_o,
  output logic [$clog2(WIDTH):0] data_o,
  output logic                   data_val_o,
  input  logic                   data_ready_i,
  output logic                   busy_o
);

  localparam int BEATS  = WIDTH / CHUNK;
  localparam int CNT_W  = $clog2(WIDTH) + 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  // Handshake: a word moves on an edge where data_val_i && data_ready_o, and a
  // result moves on an edge where data_val_o && data_ready_i. Valid holds until taken.
  typedef enum logic [1:0] {IDLE, COUNT, OUT} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  shift, shift_next;
  logic [CNT_W-1:0]  acc, acc_sum;
  logic [BEAT_W-1:0] beat;
  logic              last_beat;
  logic              accept;

  function automatic logic [CNT_W-1:0] popcount(input logic [CHUNK-1:0] bits);
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum = sum + CNT_W'(bits[i]);
    end
    return sum;
  endfunction

  assign accept     = data_val_i && data_ready_o;
  assign shift_next = shift >> CHUNK;
  assign acc_sum    = acc + popcount(shift[CHUNK-1:0]);

`ifdef POPCNT_EARLY_EXIT_EN
  assign last_beat = (beat == BEAT_W'(BEATS - 1)) || (shift_next == '0);
`else
  assign last_beat = (beat == BEAT_W'(BEATS - 1));
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = COUNT;
      COUNT:   if (last_beat) state_next = OUT;
      OUT:     if (data_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign busy_o = (state != IDLE);

  // Ready is registered so no input reaches an output combinationally.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_ready_o <= 1'b0;
      data_val_o   <= 1'b0;
      data_o       <= '0;
      shift        <= '0;
      acc          <= '0;
      beat         <= '0;
    end else begin
      data_ready_o <= (state_next == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            shift <= data_i;
            acc   <= '0;
            beat  <= '0;
          end
        end
        COUNT: begin
          acc   <= acc_sum;
          shift <= shift_next;
          beat  <= beat + 1'b1;
          if (last_beat) begin
            data_o     <= acc_sum;
            data_val_o <= 1'b1;
          end
        end
        OUT: begin
          if (data_ready_i) data_val_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_chunk_sequencer.sv
// Directed bench for popcount_chunk_sequencer: 64/8 instance plus a 16/16 instance.
module tb_popcount_chunk_sequencer;

  logic clk = 1'b0;
  logic arst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] data_i;
  logic        data_val_i, data_ready_o, data_val_o, data_ready_i, busy_o;
  logic [6:0]  data_o;

  logic [15:0] d16;
  logic        v16, r16_o, vo16, r16_i, busy16;
  logic [4:0]  o16;

  popcount_chunk_sequencer #(.WIDTH(64), .CHUNK(8)) u_dut (
    .clk_i(clk), .arst_i(arst), .data_i(data_i), .data_val_i(data_val_i),
    .data_ready_o(data_ready_o), .data_o(data_o), .data_val_o(data_val_o),
    .data_ready_i(data_ready_i), .busy_o(busy_o)
  );

  popcount_chunk_sequencer #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk_i(clk), .arst_i(arst), .data_i(d16), .data_val_i(v16),
    .data_ready_o(r16_o), .data_o(o16), .data_val_o(vo16),
    .data_ready_i(r16_i), .busy_o(busy16)
  );

  typedef struct {
    logic [63:0] word;
    logic [6:0]  count;
    int          lat_fixed;
    int          lat_early;
    string       name;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick_lat(input int lat_fixed, input int lat_early);
`ifdef POPCNT_EARLY_EXIT_EN
    return lat_early;
`else
    return lat_fixed;
`endif
  endfunction

  // Offers one word, measures edges from accept to data_val_o, leaves time at E+lat+1.
  task automatic send64(input logic [63:0] w, input logic [6:0] cnt, input int lat,
                        input string name, output int acc_cyc);
    int n;
    logic bad;
    n = 0;
    while (data_ready_o !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check({name, " ready_before"}, data_ready_o, 1);
    data_i = w;
    data_val_i = 1'b1;
    @(posedge clk); #1;
    acc_cyc = cyc;
    data_val_i = 1'b0;
    data_i = '0;
    n = 0;
    bad = 1'b0;
    while (data_val_o !== 1'b1 && n < 30) begin
      if (busy_o !== 1'b1 || data_ready_o !== 1'b0) bad = 1'b1;
      @(posedge clk); #1; n++;
    end
    if (busy_o !== 1'b1 || data_ready_o !== 1'b0) bad = 1'b1;
    check({name, " busy_not_ready"}, bad, 0);
    check({name, " latency"}, n, lat);
    check({name, " count"}, data_o, cnt);
  endtask

  task automatic send16(input logic [15:0] w, input logic [4:0] cnt, input string name);
    int n;
    n = 0;
    while (r16_o !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    d16 = w;
    v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    n = 0;
    while (vo16 !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    check({name, " latency"}, n, 1);
    check({name, " count"}, o16, cnt);
    @(posedge clk); #1;
    check({name, " val_drop"}, vo16, 0);
  endtask

  initial begin
    int a1, a2, n;
    logic bad;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 8, 8, "all_ones"};
    vecs[1] = '{64'h8000_0000_0000_0001, 7'd2,  8, 8, "ends"};
    vecs[2] = '{64'hAAAA_AAAA_AAAA_AAAA, 7'd32, 8, 8, "alt_a"};
    vecs[3] = '{64'h0000_0000_0000_0001, 7'd1,  8, 1, "one"};
    vecs[4] = '{64'h0F0F_0F0F_0F0F_0F0F, 7'd32, 8, 8, "nibbles"};
    vecs[5] = '{64'h0000_0000_0000_0000, 7'd0,  8, 1, "zero"};
    vecs[6] = '{64'h0000_0000_0000_0100, 7'd1,  8, 2, "chunk1"};
    vecs[7] = '{64'h00FF_0000_0000_0000, 7'd8,  8, 7, "chunk6"};
    vecs[8] = '{64'h1234_5678_9ABC_DEF0, 7'd32, 8, 8, "mixed"};

    // Reset state
    arst = 1'b1;
    data_i = '0; data_val_i = 1'b0; data_ready_i = 1'b1;
    d16 = '0; v16 = 1'b0; r16_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst ready", data_ready_o, 0);
    check("rst val", data_val_o, 0);
    check("rst data", data_o, 0);
    check("rst busy", busy_o, 0);
    check("rst16 ready", r16_o, 0);
    check("rst16 val", vo16, 0);
    #2 arst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle ready", data_ready_o, 1);
    check("idle busy", busy_o, 0);

    // Table of words with downstream always ready
    for (int i = 0; i < 9; i++) begin
      send64(vecs[i].word, vecs[i].count,
             pick_lat(vecs[i].lat_fixed, vecs[i].lat_early), vecs[i].name, a1);
      @(posedge clk); #1;
      check({vecs[i].name, " val_drop"}, data_val_o, 0);
      check({vecs[i].name, " data_hold"}, data_o, vecs[i].count);
      check({vecs[i].name, " idle"}, busy_o, 0);
    end

    // Back-to-back spacing
    send64(64'hAAAA_AAAA_AAAA_AAAA, 7'd32, 8, "b2b_first", a1);
    send64(64'h0000_0000_0000_0001, 7'd1, pick_lat(8, 1), "b2b_second", a2);
    check("b2b accept spacing", a2 - a1, 10);
    @(posedge clk); #1;

    // Downstream stall: result holds, a pending word is not taken
    data_ready_i = 1'b0;
    send64(64'h8000_0000_0000_0001, 7'd2, 8, "stall", a1);
    data_i = 64'hFF;
    data_val_i = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (data_o !== 7'd2 || data_val_o !== 1'b1 || data_ready_o !== 1'b0 || busy_o !== 1'b1)
        bad = 1'b1;
    end
    check("stall hold", bad, 0);
    data_ready_i = 1'b1;
    @(posedge clk); #1;
    check("stall release val", data_val_o, 0);
    check("stall release busy", busy_o, 0);
    check("stall release data", data_o, 2);
    send64(64'hFF, 7'd8, pick_lat(8, 1), "after_stall", a1);
    @(posedge clk); #1;

    // Asynchronous reset at beat 3
    n = 0;
    while (data_ready_o !== 1'b1 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    data_i = 64'hFFFF_FFFF_FFFF_FFFF;
    data_val_i = 1'b1;
    @(posedge clk); #1;
    data_val_i = 1'b0;
    repeat (3) @(posedge clk);
    #3 arst = 1'b1;
    #1;
    check("async rst ready", data_ready_o, 0);
    check("async rst val", data_val_o, 0);
    check("async rst data", data_o, 0);
    check("async rst busy", busy_o, 0);
    @(posedge clk); #3 arst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (data_val_o !== 1'b0) bad = 1'b1;
    end
    check("no partial result", bad, 0);
    send64(64'h0F0F_0F0F_0F0F_0F0F, 7'd32, 8, "post_rst", a1);
    @(posedge clk); #1;

    // Single-beat configuration
    send16(16'hFFFF, 5'd16, "w16_ones");
    send16(16'h0001, 5'd1, "w16_one");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
